text_link_ctrl: RTL

- Per-character sequencer for the text link: source -> compression -> encrypt -> Hamming enc -> BPSK mod -> channel -> demod -> Hamming dec -> decrypt -> decompression -> sink.
- Replaces the free-running start_read/start_write level with paced one-cycle strobes, one character in flight at a time.
- Detects end of message, counts characters and Hamming error events, and reports busy/done status to the top level.

---
 rtl/text_link_pkg.sv | 20 ++
 rtl/key_edge_sync.sv | 26 ++
 rtl/text_link_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/text_link_pkg.sv
// rtl/text_link_pkg.sv - shared state encoding and default widths for the text link sequencer
package text_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    READ,
    CAPTURE,
    FLIGHT,
    WRITE,
    DONE
  } link_state_t;

  localparam int DEF_CNT_W = 9;
  localparam int DEF_ERR_W = 16;
  localparam logic [7:0] DEF_TERM_CHAR = 8'h00;
  localparam int LAT_W = 8;
  localparam int RETRY_W = 8;

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - 2-FF synchroniser on the raw key plus falling-edge detect (go pulse)
module key_edge_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic start_key,
  output logic go
);

  logic sync1, sync2, sync3;

  // Stages reset to 1 so a released key never looks like a press
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= start_key;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign go = sync3 & ~sync2;

endmodule

// File: rtl/text_link_ctrl.sv
// rtl/text_link_ctrl.sv - per-character sequencer pacing read/write strobes through the text link
// Optional resend of fatal characters: TEXT_LINK_RETRY_EN
module text_link_ctrl
  import text_link_pkg::*;
#(
  parameter int         PIPE_LAT  = 4,
  parameter int         MAX_CHARS = 256,
  parameter int         CNT_W     = DEF_CNT_W,
  parameter int         ERR_W     = DEF_ERR_W,
  parameter logic [7:0] TERM_CHAR = DEF_TERM_CHAR,
  parameter int         MAX_RETRY = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start_key,
  input  logic             init_done,
  input  logic [7:0]       src_char,
  input  logic             err_corrected,
  input  logic             err_detected,
  input  logic             err_fatal,
  output logic             start_read,
  output logic             start_write,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] char_count,
  output logic [ERR_W-1:0] corr_count,
  output logic [ERR_W-1:0] fatal_count
`ifdef TEXT_LINK_RETRY_EN
  ,
  output logic             replay
`endif
);

  link_state_t      state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q;
  logic [7:0]       last_char_q;
  logic             go;
  logic             clr, cap, samp, commit;
`ifdef TEXT_LINK_RETRY_EN
  logic               retry;
  logic [RETRY_W-1:0] retry_cnt_q;
  logic               replay_q;
`endif

  key_edge_sync u_key (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start_key (start_key),
    .go        (go)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Losing init_done anywhere between READ and WRITE abandons the character
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    cap     = 1'b0;
    samp    = 1'b0;
    commit  = 1'b0;
`ifdef TEXT_LINK_RETRY_EN
    retry   = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          clr     = 1'b1;
          state_d = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (init_done) state_d = READ;
      end
      READ: begin
        state_d = init_done ? CAPTURE : WAIT_INIT;
      end
      CAPTURE: begin
        if (!init_done) state_d = WAIT_INIT;
        else begin
          cap     = 1'b1;
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (!init_done) state_d = WAIT_INIT;
        else if (lat_cnt_q == '0) begin
          samp = 1'b1;
`ifdef TEXT_LINK_RETRY_EN
          if (err_fatal && (retry_cnt_q < RETRY_W'(MAX_RETRY))) begin
            retry   = 1'b1;
            state_d = READ;
          end else
`endif
            state_d = WRITE;
        end
      end
      WRITE: begin
        if (!init_done) state_d = WAIT_INIT;
        else begin
          commit = 1'b1;
          if ((last_char_q == TERM_CHAR) ||
              ((char_count + CNT_W'(1)) == CNT_W'(MAX_CHARS)))
            state_d = DONE;
          else
            state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign start_read  = (state_q == READ) && init_done;
  assign start_write = (state_q == WRITE) && init_done;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lat_cnt_q   <= '0;
      last_char_q <= '0;
      char_count  <= '0;
    end else begin
      if (cap) begin
        lat_cnt_q   <= LAT_W'(PIPE_LAT - 1);
        last_char_q <= src_char;
      end else if (state_q == FLIGHT && lat_cnt_q != '0) begin
        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
      end
      if (clr)         char_count <= '0;
      else if (commit) char_count <= char_count + CNT_W'(1);
    end
  end

  // Fatal wins over corrected/detected; both counters stick at all-ones
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      corr_count  <= '0;
      fatal_count <= '0;
    end else if (clr) begin
      corr_count  <= '0;
      fatal_count <= '0;
    end else if (samp) begin
      if (err_fatal) begin
        if (fatal_count != '1) fatal_count <= fatal_count + ERR_W'(1);
      end else if (err_corrected || err_detected) begin
        if (corr_count != '1) corr_count <= corr_count + ERR_W'(1);
      end
    end
  end

`ifdef TEXT_LINK_RETRY_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      retry_cnt_q <= '0;
      replay_q    <= 1'b0;
    end else begin
      if (clr || commit) retry_cnt_q <= '0;
      else if (retry)    retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
      if (retry)            replay_q <= 1'b1;
      else if (clr || cap)  replay_q <= 1'b0;
    end
  end

  assign replay = start_read && replay_q;
`endif

endmodule
